reg_writeback_arbiter: RTL and testbench



---
 rtl/reg_writeback_arbiter_if.sv | 35 +++
 rtl/reg_writeback_arbiter.sv | 112 +++++++++++
 tb/tb_reg_writeback_arbiter.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_writeback_arbiter_if.sv
// Write-back arbiter bus: pipeline and long-unit write sources, scoreboard query,
// and the register-bank write port.
interface reg_writeback_arbiter_if #(
    parameter int unsigned CNTW = 3
);
    logic            iPipeWrite;
    logic [4:0]      iPipeReg;
    logic [31:0]     iPipeData;
    logic            iLongValid;
    logic [4:0]      iLongReg;
    logic [31:0]     iLongData;
    logic            oLongReady;
    logic            iIssueValid;
    logic [4:0]      iIssueReg;
    logic [4:0]      iCheckReg1;
    logic [4:0]      iCheckReg2;
    logic            oStall;
    logic [31:0]     oPending;
    logic            oRegWrite;
    logic [4:0]      oWriteRegister;
    logic [31:0]     oWriteData;
    logic [CNTW-1:0] oFifoCount;

    modport master (
        output iPipeWrite, iPipeReg, iPipeData, iLongValid, iLongReg, iLongData,
        output iIssueValid, iIssueReg, iCheckReg1, iCheckReg2,
        input  oLongReady, oStall, oPending, oRegWrite, oWriteRegister, oWriteData, oFifoCount
    );

    modport slave (
        input  iPipeWrite, iPipeReg, iPipeData, iLongValid, iLongReg, iLongData,
        input  iIssueValid, iIssueReg, iCheckReg1, iCheckReg2,
        output oLongReady, oStall, oPending, oRegWrite, oWriteRegister, oWriteData, oFifoCount
    );
endinterface

// File: rtl/reg_writeback_arbiter.sv
// Register-bank write-port arbiter: pipeline writes have priority, long-latency results
// drain from a small FIFO, and a scoreboard tracks registers with results outstanding.
module reg_writeback_arbiter #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNTW  = 3
) (
    input logic                    iCLK,
    input logic                    iCLR,
    reg_writeback_arbiter_if.slave bus
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [4:0]      mem_reg  [DEPTH];
    logic [31:0]     mem_data [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0] count_q, count_d;
    logic [31:0]     pending_q, pending_d;
    logic            wr_en_q, wr_en_d;
    logic [4:0]      wr_reg_q, wr_reg_d;
    logic [31:0]     wr_data_q, wr_data_d;

    logic            long_ready, push, pop, pipe_sel, conflict;
    logic [4:0]      head_reg;
    logic [31:0]     head_data;

    function automatic logic pending_hit(input logic [31:0] pend, input logic [4:0] r);
        return (r != 5'd0) && pend[r];
    endfunction

    assign head_reg   = mem_reg[rd_ptr_q];
    assign head_data  = mem_data[rd_ptr_q];
    assign long_ready = iCLR && (count_q < CNTW'(DEPTH));
    assign push       = bus.iLongValid && long_ready;
    // A pipeline write to $0 is treated as idle so the FIFO may drain.
    assign pipe_sel   = bus.iPipeWrite && (bus.iPipeReg != 5'd0);
    assign pop        = !pipe_sel && (count_q != '0);
    assign conflict   = bus.iIssueValid && pending_hit(pending_q, bus.iIssueReg);

    always_comb begin
        wr_en_d   = 1'b0;
        wr_reg_d  = wr_reg_q;
        wr_data_d = wr_data_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        pending_d = pending_q;

        if (pipe_sel) begin
            wr_en_d   = 1'b1;
            wr_reg_d  = bus.iPipeReg;
            wr_data_d = bus.iPipeData;
        end else if (pop) begin
            wr_en_d   = (head_reg != 5'd0);
            wr_reg_d  = head_reg;
            wr_data_d = head_data;
            rd_ptr_d  = rd_ptr_q + PW'(1);
            pending_d[head_reg] = 1'b0;
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + CNTW'(1);
            2'b01:   count_d = count_q - CNTW'(1);
            default: count_d = count_q;
        endcase

        // Applied after the pop clear so a same-cycle set wins.
        if (bus.iIssueValid && (bus.iIssueReg != 5'd0) && !conflict) begin
            pending_d[bus.iIssueReg] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge iCLK) begin
        if (!iCLR) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            pending_q <= '0;
            wr_en_q   <= 1'b0;
            wr_reg_q  <= 5'd0;
            wr_data_q <= 32'd0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            pending_q <= pending_d;
            wr_en_q   <= wr_en_d;
            wr_reg_q  <= wr_reg_d;
            wr_data_q <= wr_data_d;
        end
    end

    always_ff @(posedge iCLK) begin
        if (push) begin
            mem_reg[wr_ptr_q]  <= bus.iLongReg;
            mem_data[wr_ptr_q] <= bus.iLongData;
        end
    end

    assign bus.oLongReady     = long_ready;
    assign bus.oStall         = iCLR && (pending_hit(pending_q, bus.iCheckReg1) ||
                                         pending_hit(pending_q, bus.iCheckReg2) || conflict);
    assign bus.oPending       = pending_q;
    assign bus.oRegWrite      = wr_en_q;
    assign bus.oWriteRegister = wr_reg_q;
    assign bus.oWriteData     = wr_data_q;
    assign bus.oFifoCount     = count_q;
endmodule

// File: tb/tb_reg_writeback_arbiter.sv
// Bench for reg_writeback_arbiter: directed scenarios then random traffic, all checked
// against a queue-based reference model.
module tb_reg_writeback_arbiter;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNTW  = 3;

    logic iCLK = 1'b0;
    logic iCLR = 1'b0;

    reg_writeback_arbiter_if #(.CNTW(CNTW)) bus ();

    reg_writeback_arbiter #(.DEPTH(DEPTH), .CNTW(CNTW)) dut (
        .iCLK (iCLK),
        .iCLR (iCLR),
        .bus  (bus)
    );

    always #5 iCLK = ~iCLK;

    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
    } ent_t;

    int          checks   = 0;
    int          failures = 0;
    ent_t        q[$];
    bit          pend[32];
    logic        m_we = 1'b0;
    logic [4:0]  m_wr = 5'd0;
    logic [31:0] m_wd = 32'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit hit(input logic [4:0] r);
        return (r != 5'd0) && pend[r];
    endfunction

    function automatic logic [31:0] pend_mask();
        logic [31:0] m = '0;
        for (int i = 1; i < 32; i++) m[i] = pend[i];
        return m;
    endfunction

    task automatic idle_inputs();
        bus.iPipeWrite  = 1'b0;
        bus.iPipeReg    = 5'd0;
        bus.iPipeData   = 32'd0;
        bus.iLongValid  = 1'b0;
        bus.iLongReg    = 5'd0;
        bus.iLongData   = 32'd0;
        bus.iIssueValid = 1'b0;
        bus.iIssueReg   = 5'd0;
        bus.iCheckReg1  = 5'd0;
        bus.iCheckReg2  = 5'd0;
    endtask

    // One clock: check combinational outputs, advance the model, check registered outputs.
    task automatic cycle();
        bit   ready, conflict, pipe;
        ent_t h;
        #1;
        ready    = iCLR && (q.size() < DEPTH);
        conflict = bus.iIssueValid && hit(bus.iIssueReg);
        check("long_ready", bus.oLongReady, ready);
        check("stall", bus.oStall,
              iCLR && (hit(bus.iCheckReg1) || hit(bus.iCheckReg2) || conflict));
        if (!iCLR) begin
            q.delete();
            for (int i = 0; i < 32; i++) pend[i] = 1'b0;
            m_we = 1'b0;
            m_wr = 5'd0;
            m_wd = 32'd0;
        end else begin
            pipe = bus.iPipeWrite && (bus.iPipeReg != 5'd0);
            if (pipe) begin
                m_we = 1'b1;
                m_wr = bus.iPipeReg;
                m_wd = bus.iPipeData;
            end else if (q.size() > 0) begin
                h       = q.pop_front();
                m_we    = (h.r != 5'd0);
                m_wr    = h.r;
                m_wd    = h.d;
                pend[h.r] = 1'b0;
            end else begin
                m_we = 1'b0;
            end
            if (bus.iLongValid && ready) begin
                h.r = bus.iLongReg;
                h.d = bus.iLongData;
                q.push_back(h);
            end
            if (bus.iIssueValid && (bus.iIssueReg != 5'd0) && !conflict) pend[bus.iIssueReg] = 1'b1;
            pend[0] = 1'b0;
        end
        @(posedge iCLK);
        #1;
        check("reg_write", bus.oRegWrite, m_we);
        check("write_reg", bus.oWriteRegister, m_wr);
        check("write_data", bus.oWriteData, m_wd);
        check("fifo_count", bus.oFifoCount, 32'(q.size()));
        check("pending", bus.oPending, pend_mask());
    endtask

    initial begin
        idle_inputs();
        for (int i = 0; i < 32; i++) pend[i] = 1'b0;

        // Reset state
        iCLR = 1'b0;
        cycle();
        cycle();
        check("rst_regwrite", bus.oRegWrite, 1'b0);
        check("rst_count", bus.oFifoCount, 0);
        check("rst_pending", bus.oPending, 0);
        check("rst_ready", bus.oLongReady, 1'b0);
        iCLR = 1'b1;
        cycle();

        // 1: single pipeline write
        bus.iPipeWrite = 1'b1; bus.iPipeReg = 5'd5; bus.iPipeData = 32'hDEADBEEF;
        cycle();
        idle_inputs();
        check("t1_we", bus.oRegWrite, 1'b1);
        check("t1_reg", bus.oWriteRegister, 5'd5);
        check("t1_data", bus.oWriteData, 32'hDEADBEEF);
        cycle();
        check("t1_we_off", bus.oRegWrite, 1'b0);

        // 2: issue, stall, long result clears pending
        bus.iIssueValid = 1'b1; bus.iIssueReg = 5'd8;
        cycle();
        idle_inputs();
        check("t2_pend8", bus.oPending[8], 1'b1);
        bus.iCheckReg1 = 5'd8;
        #1;
        check("t2_stall", bus.oStall, 1'b1);
        bus.iLongValid = 1'b1; bus.iLongReg = 5'd8; bus.iLongData = 32'h12345678;
        cycle();
        bus.iLongValid = 1'b0;
        check("t2_count1", bus.oFifoCount, 1);
        cycle();
        check("t2_we", bus.oRegWrite, 1'b1);
        check("t2_reg", bus.oWriteRegister, 5'd8);
        check("t2_data", bus.oWriteData, 32'h12345678);
        check("t2_pend8_clr", bus.oPending[8], 1'b0);
        check("t2_stall_clr", bus.oStall, 1'b0);
        idle_inputs();

        // 3: pipeline priority fills the FIFO, then drain in order
        for (int i = 0; i < 6; i++) begin
            bus.iPipeWrite = 1'b1; bus.iPipeReg = 5'(i + 1); bus.iPipeData = 32'(100 + i);
            bus.iLongValid = (i < 5);
            bus.iLongReg   = 5'(10 + i);
            bus.iLongData  = 32'hC000 + 32'(i);
            cycle();
        end
        check("t3_count4", bus.oFifoCount, 4);
        check("t3_ready0", bus.oLongReady, 1'b0);
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("t3_drain_reg", bus.oWriteRegister, 5'(10 + i));
            check("t3_drain_data", bus.oWriteData, 32'hC000 + 32'(i));
            if (i == 0) check("t3_ready1", bus.oLongReady, 1'b1);
        end
        cycle();
        check("t3_idle", bus.oRegWrite, 1'b0);

        // 4: WAW conflict ignored; set wins over same-cycle pop clear
        bus.iIssueValid = 1'b1; bus.iIssueReg = 5'd9;
        cycle();
        #1;
        check("t4_conflict_stall", bus.oStall, 1'b1);
        cycle();
        check("t4_pend9", bus.oPending[9], 1'b1);
        idle_inputs();
        bus.iLongValid = 1'b1; bus.iLongReg = 5'd9; bus.iLongData = 32'h9999;
        cycle();
        idle_inputs();
        cycle();
        check("t4_pend9_clr", bus.oPending[9], 1'b0);
        bus.iLongValid = 1'b1; bus.iLongReg = 5'd9; bus.iLongData = 32'h9A9A;
        cycle();
        idle_inputs();
        bus.iIssueValid = 1'b1; bus.iIssueReg = 5'd9;
        cycle();
        idle_inputs();
        check("t4_set_wins", bus.oPending[9], 1'b1);
        check("t4_pop_reg", bus.oWriteRegister, 5'd9);
        bus.iLongValid = 1'b1; bus.iLongReg = 5'd9; bus.iLongData = 32'h9B9B;
        cycle();
        idle_inputs();
        cycle();

        // 5: writes to $0
        bus.iLongValid = 1'b1; bus.iLongReg = 5'd3; bus.iLongData = 32'hA;
        cycle();
        idle_inputs();
        bus.iPipeWrite = 1'b1; bus.iPipeReg = 5'd0; bus.iPipeData = 32'hFFFF;
        cycle();
        idle_inputs();
        check("t5_pop_we", bus.oRegWrite, 1'b1);
        check("t5_pop_reg", bus.oWriteRegister, 5'd3);
        check("t5_pop_data", bus.oWriteData, 32'hA);
        bus.iLongValid = 1'b1; bus.iLongReg = 5'd0; bus.iLongData = 32'h55;
        cycle();
        idle_inputs();
        cycle();
        check("t5_r0_drop", bus.oRegWrite, 1'b0);
        bus.iIssueValid = 1'b1; bus.iIssueReg = 5'd0;
        cycle();
        idle_inputs();
        check("t5_issue_r0", bus.oPending, 0);

        // 6: reset discards queued results and pending bits
        for (int i = 0; i < 3; i++) begin
            bus.iPipeWrite = 1'b1; bus.iPipeReg = 5'd20; bus.iPipeData = 32'(i);
            bus.iLongValid = 1'b1; bus.iLongReg = 5'(11 + i); bus.iLongData = 32'hE0 + 32'(i);
            bus.iIssueValid = 1'b1; bus.iIssueReg = 5'(11 + i);
            cycle();
        end
        idle_inputs();
        check("t6_pre_count", bus.oFifoCount, 3);
        iCLR = 1'b0;
        cycle();
        check("t6_count", bus.oFifoCount, 0);
        check("t6_pending", bus.oPending, 0);
        check("t6_we", bus.oRegWrite, 1'b0);
        iCLR = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("t6_no_drain", bus.oRegWrite, 1'b0);
        end

        // Random traffic with occasional reset
        for (int n = 0; n < 400; n++) begin
            iCLR            = ($urandom_range(0, 59) != 0);
            bus.iPipeWrite  = ($urandom_range(0, 2) == 0);
            bus.iPipeReg    = 5'($urandom_range(0, 7));
            bus.iPipeData   = $urandom;
            bus.iLongValid  = ($urandom_range(0, 1) == 0);
            bus.iLongReg    = 5'($urandom_range(0, 7));
            bus.iLongData   = $urandom;
            bus.iIssueValid = ($urandom_range(0, 2) == 0);
            bus.iIssueReg   = 5'($urandom_range(0, 7));
            bus.iCheckReg1  = 5'($urandom_range(0, 7));
            bus.iCheckReg2  = 5'($urandom_range(0, 31));
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
